// File: rtl/conv1_layer1_pkg.sv
// Shared conv1 layer-1 constants and the dense accumulator state encoding.
// The mxmult stage imports the same package so both agree on word packing.
package conv1_layer1_pkg;

  localparam int C1_LANES      = 25;  // signed lanes per product word
  localparam int C1_LANE_W     = 16;  // lane width in bits
  localparam int C1_ACC_W      = 24;  // accumulator width in bits
  localparam int C1_ACC_LEN    = 9;   // product beats summed per output word
  localparam int C1_NUM_GROUPS = 64;  // output words per run

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/conv1_layer1_relu_sat.sv
// ReLU plus saturation of one accumulator lane down to a lane-wide value.
module conv1_layer1_relu_sat
  import conv1_layer1_pkg::*;
#(
  parameter int ACC_W  = C1_ACC_W,
  parameter int LANE_W = C1_LANE_W
) (
  input  logic [ACC_W-1:0]  sum,
  output logic [LANE_W-1:0] lane
);

  // Largest positive value a signed lane can hold.
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (LANE_W - 1)) - 1);

  // Negative sums clamp to zero, large positive sums clamp to SAT_MAX.
  always_comb begin
    // NOTE: assign a default first so every path drives lane and no latch is inferred.
    lane = sum[LANE_W-1:0];
    if (sum[ACC_W-1]) begin
      lane = '0;
    end else if (sum > SAT_MAX) begin
      lane = SAT_MAX[LANE_W-1:0];
    end
  end

endmodule

// File: rtl/conv1_layer1_dense_acc.sv
// Dense accumulator for conv1 layer 1: sums ACC_LEN product beats per lane,
// applies ReLU/saturation and hands NUM_GROUPS words downstream per run.
module conv1_layer1_dense_acc
  import conv1_layer1_pkg::*;
#(
  parameter int LANES      = C1_LANES,
  parameter int LANE_W     = C1_LANE_W,
  parameter int ACC_W      = C1_ACC_W,
  parameter int ACC_LEN    = C1_ACC_LEN,
  parameter int NUM_GROUPS = C1_NUM_GROUPS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mult_res_v,
  input  logic [LANES*LANE_W-1:0] mult_res,
  input  logic                    out_ready,
  output logic                    need_data,
  output logic                    out_v,
  output logic [LANES*LANE_W-1:0] out_fea,
  output logic                    done,
  output logic                    overflow_err
);

  localparam int BEAT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int GRP_W  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ACC_LEN - 1);
  localparam logic [GRP_W-1:0]  LAST_GRP  = GRP_W'(NUM_GROUPS - 1);

  state_t            state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [GRP_W-1:0]  grp_cnt;

  logic signed [ACC_W-1:0] acc     [LANES];
  logic signed [ACC_W-1:0] acc_sum [LANES];
  logic [LANES*LANE_W-1:0] fea_next;

  // Per lane: sign-extend the incoming product, add it to the running sum,
  // and clamp the updated sum so the last beat's result can be registered directly.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] lane_in;
    assign lane_in    = mult_res[i*LANE_W +: LANE_W];
    assign acc_sum[i] = acc[i] + {{(ACC_W - LANE_W){lane_in[LANE_W-1]}}, lane_in};

    conv1_layer1_relu_sat #(
      .ACC_W  (ACC_W),
      .LANE_W (LANE_W)
    ) u_relu_sat (
      .sum  (acc_sum[i]),
      .lane (fea_next[i*LANE_W +: LANE_W])
    );
  end

  // Run control FSM with registered outputs, accumulators and result word.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // updates from pre-edge values regardless of statement order.
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      grp_cnt      <= '0;
      out_fea      <= '0;
      out_v        <= 1'b0;
      done         <= 1'b0;
      need_data    <= 1'b0;
      overflow_err <= 1'b0;
      // NOTE: the accumulator array is reset explicitly because a run abandoned
      // mid-group must not leak partial sums into the next observable state.
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_ACC;
            need_data    <= 1'b1;
            beat_cnt     <= '0;
            grp_cnt      <= '0;
            overflow_err <= 1'b0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
          end
          // A beat with nowhere to go is dropped and flagged; this wins over
          // the clear from a simultaneous start.
          if (mult_res_v) overflow_err <= 1'b1;
        end

        ST_ACC: begin
          if (mult_res_v) begin
            for (int i = 0; i < LANES; i++) acc[i] <= acc_sum[i];
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt  <= '0;
              out_fea   <= fea_next;
              out_v     <= 1'b1;
              need_data <= 1'b0;
              state     <= ST_OUT;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        ST_OUT: begin
          if (mult_res_v) overflow_err <= 1'b1;
          // out_v is always high here, so out_ready alone completes the handshake.
          if (out_ready) begin
            out_v <= 1'b0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
            if (grp_cnt == LAST_GRP) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              grp_cnt   <= grp_cnt + 1'b1;
              need_data <= 1'b1;
              state     <= ST_ACC;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_layer1_dense_acc.sv
// Self-checking bench for conv1_layer1_dense_acc with a two-group run length.
module tb_conv1_layer1_dense_acc;

  localparam int LANES   = 25;
  localparam int LANE_W  = 16;
  localparam int ACC_LEN = 9;
  localparam int W       = LANES * LANE_W;

  typedef struct {
    string       name;
    logic [15:0] l0, l1, lr;  // per-beat input: lane0, lane1, all other lanes
    logic [15:0] e0, e1, er;  // expected output lanes after ACC_LEN beats
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mult_res_v;
  logic [W-1:0] mult_res;
  logic         out_ready;
  logic         need_data;
  logic         out_v;
  logic [W-1:0] out_fea;
  logic         done;
  logic         overflow_err;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] sb[$];
  vec_t vecs[6];

  conv1_layer1_dense_acc #(
    .NUM_GROUPS (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mult_res_v   (mult_res_v),
    .mult_res     (mult_res),
    .out_ready    (out_ready),
    .need_data    (need_data),
    .out_v        (out_v),
    .out_fea      (out_fea),
    .done         (done),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [15:0] a0, input logic [15:0] a1,
                                        input logic [15:0] ar);
    logic [W-1:0] w;
    for (int i = 0; i < LANES; i++) w[i*LANE_W +: LANE_W] = ar;
    w[15:0]  = a0;
    w[31:16] = a1;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_v && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_fea_unexpected: got %h expected no output", out_fea);
      end else begin
        check("out_fea", out_fea, sb.pop_front());
      end
    end
  end

  // Wait for need_data, then drive ACC_LEN beats (optionally with idle gaps).
  task automatic send_group(input vec_t v, input bit gap);
    int guard = 0;
    while (!need_data && guard < 20) begin
      tick();
      guard++;
    end
    check({"need_data_", v.name}, W'(need_data), W'(1));
    for (int b = 0; b < ACC_LEN; b++) begin
      mult_res   = pack(v.l0, v.l1, v.lr);
      mult_res_v = 1'b1;
      if (b == ACC_LEN - 1) begin
        sb.push_back(pack(v.e0, v.e1, v.er));
        check({"out_v_early_", v.name}, W'(out_v), W'(0));
      end
      tick();
      if (gap && b < ACC_LEN - 1) begin
        mult_res_v = 1'b0;
        mult_res   = '1;
        tick();
        tick();
      end
    end
    mult_res_v = 1'b0;
    check({"out_v_latency_", v.name}, W'(out_v), W'(1));
  endtask

  // One full run of two groups; optionally back-pressure the first output.
  task automatic run_pair(input vec_t a, input vec_t b, input bit gap, input bit hold);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("overflow_clear_on_start", W'(overflow_err), W'(0));
    out_ready = !hold;
    send_group(a, gap);
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        check("hold_out_v", W'(out_v), W'(1));
        check("hold_need_data", W'(need_data), W'(0));
        check("hold_out_fea", out_fea, pack(a.e0, a.e1, a.er));
        mult_res_v = (c == 2);
        mult_res   = pack(16'h1234, 16'h1234, 16'h1234);
        tick();
        mult_res_v = 1'b0;
      end
      check("overflow_set", W'(overflow_err), W'(1));
      out_ready = 1'b1;
    end
    send_group(b, gap);
    check("done_before_hs", W'(done), W'(0));
    tick();
    check("done_pulse", W'(done), W'(1));
    check("idle_out_v", W'(out_v), W'(0));
    check("idle_need_data", W'(need_data), W'(0));
    tick();
    check("done_single", W'(done), W'(0));
    check("overflow_sticky", W'(overflow_err), W'(hold));
  endtask

  initial begin
    vecs[0] = '{"ones",     16'h0001, 16'h0001, 16'h0001, 16'd9,     16'd9,     16'd9};
    vecs[1] = '{"minmax",   16'h8000, 16'h7FFF, 16'h0005, 16'd0,     16'd32767, 16'd45};
    vecs[2] = '{"neg1",     16'hFFFF, 16'd100,  16'd3640, 16'd0,     16'd900,   16'd32760};
    vecs[3] = '{"edge_sat", 16'd3641, 16'hFFF0, 16'h0000, 16'd32767, 16'd0,     16'd0};
    vecs[4] = '{"near_max", 16'd3640, 16'hF1C8, 16'h0002, 16'd32760, 16'd0,     16'd18};
    vecs[5] = '{"big",      16'h1000, 16'h0000, 16'hFFFE, 16'd32767, 16'd0,     16'd0};

    rst        = 1'b1;
    start      = 1'b0;
    mult_res_v = 1'b0;
    mult_res   = '0;
    out_ready  = 1'b1;
    repeat (3) tick();
    check("rst_out_v", W'(out_v), W'(0));
    check("rst_need_data", W'(need_data), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_overflow", W'(overflow_err), W'(0));
    check("rst_out_fea", out_fea, '0);
    rst = 1'b0;

    // Start accepted on the first cycle out of reset.
    run_pair(vecs[0], vecs[1], 1'b0, 1'b0);
    // Gapped beats plus back-pressure with a stray beat during OUT.
    run_pair(vecs[2], vecs[3], 1'b1, 1'b1);

    // Abort a run after four beats with reset.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mult_res   = pack(16'h0100, 16'h0100, 16'h0100);
      mult_res_v = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    mult_res_v = 1'b0;
    check("abort_out_v", W'(out_v), W'(0));
    check("abort_need_data", W'(need_data), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_out_fea", out_fea, '0);
    rst = 1'b0;
    run_pair(vecs[4], vecs[5], 1'b0, 1'b0);

    repeat (2) tick();
    check("scoreboard_drained", W'(sb.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
